// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared types and default sizes for the Collatz runner
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_IN_W      = 8;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_STEP_W    = 8;
  localparam int DEF_MAX_STEPS = 255;

endpackage

// File: rtl/collatz_if.sv
// rtl/collatz_if.sv - start/busy/done handshake and result bundle
interface collatz_if
  import collatz_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) ();

  logic              start;
  logic [IN_W-1:0]   seed;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  peak;
  logic              overflow;
  logic              timeout;
  logic              zero_err;

  modport master (
    output start, seed,
    input  busy, done, steps, peak, overflow, timeout, zero_err
  );

  modport slave (
    input  start, seed,
    output busy, done, steps, peak, overflow, timeout, zero_err
  );

endinterface

// File: rtl/collatz_step.sv
// rtl/collatz_step.sv - one combinational Collatz step with overflow detect
module collatz_step
  import collatz_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);

  logic [WIDTH+1:0] wide;

  // Even halves, odd goes to 3n+1 in two extra bits so a carry-out is visible; 1 is a fixed point
  always_comb begin
    wide = '0;
    nxt  = n;
    ovf  = 1'b0;
    if (n == WIDTH'(1)) begin
      nxt = n;
    end else if (n[0]) begin
      wide = ({2'b00, n} << 1) + {2'b00, n} + (WIDTH+2)'(1);
      ovf  = |wide[WIDTH+1:WIDTH];
      nxt  = wide[WIDTH-1:0];
    end else begin
      nxt = n >> 1;
    end
  end

endmodule

// File: rtl/collatz_runner.sv
// rtl/collatz_runner.sv - iterates the Collatz step to 1, tracking steps, peak and aborts
module collatz_runner
  import collatz_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input logic      clk,
  input logic      rst_n,
  collatz_if.slave bus
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0]  peak_q, peak_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic              zero_err_q, zero_err_d;

  logic [WIDTH-1:0]  step_nxt;
  logic              step_ovf;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .n   (n_q),
    .nxt (step_nxt),
    .ovf (step_ovf)
  );

  // Next-state: accept a seed in IDLE, iterate in RUN with abort checks in priority order
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    steps_d    = steps_q;
    peak_d     = peak_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    zero_err_d = zero_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          steps_d    = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
          zero_err_d = 1'b0;
          if (bus.seed != IN_W'(0)) begin
            n_d     = WIDTH'(bus.seed);
            peak_d  = WIDTH'(bus.seed);
            state_d = RUN;
          end else begin
            peak_d     = '0;
            zero_err_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      RUN: begin
        if (n_q == WIDTH'(1)) begin
          state_d = DONE;
        end else if (steps_q == STEP_W'(MAX_STEPS)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (step_ovf) begin
          // n and steps stay frozen so the caller sees where the run stopped
          overflow_d = 1'b1;
          state_d    = DONE;
        end else begin
          n_d     = step_nxt;
          steps_d = steps_q + STEP_W'(1);
          if (step_nxt > peak_q) begin
            peak_d = step_nxt;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any run without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      steps_q    <= '0;
      peak_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      steps_q    <= steps_d;
      peak_q     <= peak_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.steps    = steps_q;
  assign bus.peak     = peak_q;
  assign bus.overflow = overflow_q;
  assign bus.timeout  = timeout_q;
  assign bus.zero_err = zero_err_q;

endmodule
